alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 37 +++
 rtl/alu_arbiter_if.sv | 55 +++++
 rtl/alu_arbiter_alu.sv | 62 ++++++
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared instruction definitions: ALU command encodings, flag bit positions and widths
// used by the arbiter, its ALU and the bus interface.
package alu_arbiter_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned CmdW  = 4;
  localparam int unsigned TagW  = 4;
  localparam int unsigned FlagW = 4;
  localparam int unsigned CntW  = 16;

  typedef enum logic [CmdW-1:0] {
    CmdMov = 4'd0,
    CmdMvn = 4'd1,
    CmdAdd = 4'd2,
    CmdAdc = 4'd3,
    CmdSub = 4'd4,
    CmdSbc = 4'd5,
    CmdAnd = 4'd6,
    CmdOr  = 4'd7,
    CmdEor = 4'd8,
    CmdCmp = 4'd9,
    CmdTst = 4'd10,
    CmdLdr = 4'd11,
    CmdStr = 4'd12
  } cmd_e;

  // Flag vector is ordered {Z,C,N,V}.
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagV = 0;

  function automatic logic updates_flags(input logic [CmdW-1:0] cmd, input logic s);
    return s | (cmd == CmdCmp) | (cmd == CmdTst);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle for the arbiter: two requester channels, the result slot, flush and
// architectural status/counter outputs.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic             r0_valid;
  logic             r0_ready;
  logic [CmdW-1:0]  r0_cmd;
  logic [DataW-1:0] r0_a;
  logic [DataW-1:0] r0_b;
  logic             r0_s;
  logic [TagW-1:0]  r0_tag;

  logic             r1_valid;
  logic             r1_ready;
  logic [CmdW-1:0]  r1_cmd;
  logic [DataW-1:0] r1_a;
  logic [DataW-1:0] r1_b;
  logic             r1_s;
  logic [TagW-1:0]  r1_tag;

  logic             out_valid;
  logic             out_ready;
  logic [DataW-1:0] out_result;
  logic [FlagW-1:0] out_status;
  logic             out_src;
  logic [TagW-1:0]  out_tag;

  logic             flush;
  logic [FlagW-1:0] status_reg;
  logic [CntW-1:0]  grant_cnt;

  modport master (
    output r0_valid, r0_cmd, r0_a, r0_b, r0_s, r0_tag,
    input  r0_ready,
    output r1_valid, r1_cmd, r1_a, r1_b, r1_s, r1_tag,
    input  r1_ready,
    input  out_valid, out_result, out_status, out_src, out_tag,
    output out_ready,
    output flush,
    input  status_reg, grant_cnt
  );

  modport slave (
    input  r0_valid, r0_cmd, r0_a, r0_b, r0_s, r0_tag,
    output r0_ready,
    input  r1_valid, r1_cmd, r1_a, r1_b, r1_s, r1_tag,
    output r1_ready,
    output out_valid, out_result, out_status, out_src, out_tag,
    input  out_ready,
    input  flush,
    output status_reg, grant_cnt
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: one shared adder for arithmetic commands, a logic unit for
// the rest, and {Z,C,N,V} flag generation.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [CmdW-1:0]  cmd_i,
  input  logic [DataW-1:0] a_i,
  input  logic [DataW-1:0] b_i,
  input  logic             cin_i,
  output logic [DataW-1:0] result_o,
  output logic [FlagW-1:0] flags_o
);

  logic [DataW-1:0] b_op;
  logic             c_add;
  logic             is_arith;
  logic [DataW:0]   sum;
  logic [DataW-1:0] logic_res;

  // Subtraction is a + ~b + 1 (or + C for SBC), so C means "no borrow".
  always_comb begin
    b_op     = b_i;
    c_add    = 1'b0;
    is_arith = 1'b1;
    case (cmd_i)
      CmdAdd, CmdLdr, CmdStr: c_add = 1'b0;
      CmdAdc:                 c_add = cin_i;
      CmdSub, CmdCmp: begin
        b_op  = ~b_i;
        c_add = 1'b1;
      end
      CmdSbc: begin
        b_op  = ~b_i;
        c_add = cin_i;
      end
      default:                is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, a_i} + {1'b0, b_op} + {{DataW{1'b0}}, c_add};

  always_comb begin
    case (cmd_i)
      CmdMov:         logic_res = b_i;
      CmdMvn:         logic_res = ~b_i;
      CmdAnd, CmdTst: logic_res = a_i & b_i;
      CmdOr:          logic_res = a_i | b_i;
      CmdEor:         logic_res = a_i ^ b_i;
      default:        logic_res = '0;
    endcase
  end

  assign result_o = is_arith ? sum[DataW-1:0] : logic_res;

  // Logical commands pass the incoming carry through and clear overflow.
  assign flags_o[FlagZ] = (result_o == '0);
  assign flags_o[FlagC] = is_arith ? sum[DataW] : cin_i;
  assign flags_o[FlagN] = result_o[DataW-1];
  assign flags_o[FlagV] = is_arith & (a_i[DataW-1] == b_op[DataW-1]) &
                          (sum[DataW-1] != a_i[DataW-1]);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single ALU with a one-deep registered result
// slot, architectural flag register and accepted-operation counter.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  alu_arbiter_if.slave bus
);

  logic             out_valid_q, out_valid_d;
  logic [DataW-1:0] out_result_q, out_result_d;
  logic [FlagW-1:0] out_status_q, out_status_d;
  logic             out_src_q, out_src_d;
  logic [TagW-1:0]  out_tag_q, out_tag_d;
  logic [FlagW-1:0] status_q, status_d;
  logic [CntW-1:0]  grant_cnt_q, grant_cnt_d;
  logic             last_grant_q, last_grant_d;

  logic             slot_free;
  logic             can_grant;
  logic             sel;
  logic             xfer;
  logic [CmdW-1:0]  sel_cmd;
  logic [DataW-1:0] sel_a;
  logic [DataW-1:0] sel_b;
  logic             sel_s;
  logic [TagW-1:0]  sel_tag;
  logic [DataW-1:0] alu_result;
  logic [FlagW-1:0] alu_flags;

  assign slot_free = ~out_valid_q | bus.out_ready;
  assign can_grant = slot_free & ~bus.flush & rst;

  // sel=1 picks requester 1; on contention the one not granted last wins.
  assign sel = (bus.r0_valid & bus.r1_valid) ? ~last_grant_q : ~bus.r0_valid;

  assign bus.r0_ready = can_grant & bus.r0_valid & ~sel;
  assign bus.r1_ready = can_grant & bus.r1_valid & sel;
  assign xfer         = bus.r0_ready | bus.r1_ready;

  assign sel_cmd = sel ? bus.r1_cmd : bus.r0_cmd;
  assign sel_a   = sel ? bus.r1_a   : bus.r0_a;
  assign sel_b   = sel ? bus.r1_b   : bus.r0_b;
  assign sel_s   = sel ? bus.r1_s   : bus.r0_s;
  assign sel_tag = sel ? bus.r1_tag : bus.r0_tag;

  alu_arbiter_alu u_alu (
    .cmd_i    (sel_cmd),
    .a_i      (sel_a),
    .b_i      (sel_b),
    .cin_i    (status_q[FlagC]),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_status_d = out_status_q;
    out_src_d    = out_src_q;
    out_tag_d    = out_tag_q;
    status_d     = status_q;
    grant_cnt_d  = grant_cnt_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_status_d = alu_flags;
      out_src_d    = sel;
      out_tag_d    = sel_tag;
      grant_cnt_d  = grant_cnt_q + 1'b1;
      last_grant_d = sel;
      if (updates_flags(sel_cmd, sel_s)) begin
        status_d = alu_flags;
      end
    end else if (bus.flush | bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_status_q <= '0;
      out_src_q    <= 1'b0;
      out_tag_q    <= '0;
      status_q     <= '0;
      grant_cnt_q  <= '0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_status_q <= out_status_d;
      out_src_q    <= out_src_d;
      out_tag_q    <= out_tag_d;
      status_q     <= status_d;
      grant_cnt_q  <= grant_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_status = out_status_q;
  assign bus.out_src    = out_src_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.status_reg = status_q;
  assign bus.grant_cnt  = grant_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk;
  logic rst;
  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model state.
  logic        m_valid = 1'b0;
  logic [31:0] m_res   = '0;
  logic [3:0]  m_stat  = '0;
  logic        m_src   = 1'b0;
  logic [3:0]  m_tag   = '0;
  logic [3:0]  m_sreg  = '0;
  logic        m_last  = 1'b1;
  logic [15:0] m_cnt   = '0;

  // Returns {Z,C,N,V, result}.
  function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [32:0] w;
    logic [31:0] r;
    logic        c;
    logic        v;
    w = '0;
    r = '0;
    c = cin;
    v = 1'b0;
    case (cmd)
      CmdAdd, CmdLdr, CmdStr, CmdAdc: begin
        w = {1'b0, a} + {1'b0, b} + ((cmd == CmdAdc) ? {32'd0, cin} : 33'd0);
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      CmdSub, CmdCmp, CmdSbc: begin
        w = {1'b0, a} - {1'b0, b} - ((cmd == CmdSbc) ? {32'd0, ~cin} : 33'd0);
        r = w[31:0];
        c = ~w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      CmdMov:         r = b;
      CmdMvn:         r = ~b;
      CmdAnd, CmdTst: r = a & b;
      CmdOr:          r = a | b;
      CmdEor:         r = a ^ b;
      default:        r = '0;
    endcase
    return {(r == 32'd0), c, r[31], v, r};
  endfunction

  // Which requester the model would grant right now; -1 when none.
  function automatic int m_pick();
    if (!rst || bus.flush || (m_valid && !bus.out_ready)) return -1;
    if (bus.r0_valid && bus.r1_valid) return m_last ? 0 : 1;
    if (bus.r0_valid) return 0;
    if (bus.r1_valid) return 1;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_valid = 1'b0; m_res = '0; m_stat = '0; m_src = 1'b0; m_tag = '0;
        m_sreg = '0; m_last = 1'b1; m_cnt = '0;
      end else begin
        int          g;
        logic [35:0] o;
        logic [3:0]  cmd;
        logic        s;
        g = m_pick();
        if (g >= 0) begin
          cmd = (g == 1) ? bus.r1_cmd : bus.r0_cmd;
          s   = (g == 1) ? bus.r1_s : bus.r0_s;
          o   = (g == 1) ? m_alu(cmd, bus.r1_a, bus.r1_b, m_sreg[2])
                         : m_alu(cmd, bus.r0_a, bus.r0_b, m_sreg[2]);
          m_valid = 1'b1;
          m_res   = o[31:0];
          m_stat  = o[35:32];
          m_src   = (g == 1);
          m_tag   = (g == 1) ? bus.r1_tag : bus.r0_tag;
          m_last  = (g == 1);
          m_cnt   = m_cnt + 16'd1;
          if (s || cmd == CmdCmp || cmd == CmdTst) m_sreg = o[35:32];
        end else if (bus.flush || bus.out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      int g;
      @(negedge clk);
      g = m_pick();
      chk("r0_ready", 32'(bus.r0_ready), 32'(g == 0));
      chk("r1_ready", 32'(bus.r1_ready), 32'(g == 1));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("status_reg", 32'(bus.status_reg), 32'(m_sreg));
      chk("grant_cnt", 32'(bus.grant_cnt), 32'(m_cnt));
      if (m_valid) begin
        chk("out_result", bus.out_result, m_res);
        chk("out_status", 32'(bus.out_status), 32'(m_stat));
        chk("out_src", 32'(bus.out_src), 32'(m_src));
        chk("out_tag", 32'(bus.out_tag), 32'(m_tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int idx, input logic [3:0] cmd, input logic [31:0] a,
                     input logic [31:0] b, input logic s, input logic [3:0] tag);
    if (idx == 0) begin
      bus.r0_valid = 1'b1; bus.r0_cmd = cmd; bus.r0_a = a; bus.r0_b = b;
      bus.r0_s = s; bus.r0_tag = tag;
    end else begin
      bus.r1_valid = 1'b1; bus.r1_cmd = cmd; bus.r1_a = a; bus.r1_b = b;
      bus.r1_s = s; bus.r1_tag = tag;
    end
  endtask

  task automatic idle();
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.r0_valid = 1'b0; bus.r0_cmd = '0; bus.r0_a = '0; bus.r0_b = '0;
    bus.r0_s = 1'b0; bus.r0_tag = '0;
    bus.r1_valid = 1'b0; bus.r1_cmd = '0; bus.r1_a = '0; bus.r1_b = '0;
    bus.r1_s = 1'b0; bus.r1_tag = '0;
    #1 rst = 1'b0;

    // Reset: valid request must not be acknowledged.
    req(0, CmdAdd, 32'd1, 32'd1, 1'b0, 4'd0);
    tick();
    tick();
    chk("rst_r0_ready", 32'(bus.r0_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_grant_cnt", 32'(bus.grant_cnt), 32'd0);
    idle();
    rst = 1'b1;
    tick();

    // Signed overflow into bit 31.
    req(0, CmdAdd, 32'h7FFF_FFFF, 32'd1, 1'b1, 4'd3);
    #1 chk("ovf_r0_ready", 32'(bus.r0_ready), 32'd1);
    tick();
    idle();
    chk("ovf_result", bus.out_result, 32'h8000_0000);
    chk("ovf_status_reg", 32'(bus.status_reg), 32'h3);
    chk("ovf_src", 32'(bus.out_src), 32'd0);
    chk("ovf_tag", 32'(bus.out_tag), 32'd3);
    chk("model_ovf", 32'(m_sreg), 32'h3);

    // Carry forwarded through status_reg into a back-to-back ADC.
    req(1, CmdAdd, 32'hFFFF_FFFF, 32'd1, 1'b1, 4'd1);
    tick();
    chk("carry_status", 32'(bus.status_reg), 32'hC);
    req(1, CmdAdc, 32'd0, 32'd0, 1'b0, 4'd2);
    tick();
    idle();
    chk("adc_result", bus.out_result, 32'd1);
    chk("adc_src", 32'(bus.out_src), 32'd1);
    chk("adc_status_hold", 32'(bus.status_reg), 32'hC);
    chk("model_adc", m_res, 32'd1);

    // MOV with s=1, then CMP updates flags without s, MOV/LDR without s hold them.
    req(0, CmdMov, 32'd0, 32'd1, 1'b1, 4'd4);
    tick();
    chk("mov_s_status", 32'(bus.status_reg), 32'h4);
    req(0, CmdCmp, 32'd5, 32'd5, 1'b0, 4'd5);
    tick();
    chk("cmp_z", 32'(bus.status_reg[3]), 32'd1);
    chk("cmp_status", 32'(bus.status_reg), 32'hC);
    req(0, CmdMov, 32'd0, 32'd0, 1'b0, 4'd6);
    tick();
    chk("mov_hold", 32'(bus.status_reg), 32'hC);
    chk("mov_result", bus.out_result, 32'd0);
    req(0, CmdLdr, 32'd10, 32'd20, 1'b0, 4'd7);
    tick();
    idle();
    chk("ldr_result", bus.out_result, 32'd30);
    chk("ldr_hold", 32'(bus.status_reg), 32'hC);

    // Reset mid-stream: slot and flags cleared immediately.
    req(0, CmdAdd, 32'd7, 32'd8, 1'b1, 4'd8);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_status", 32'(bus.status_reg), 32'd0);
    chk("midrst_cnt", 32'(bus.grant_cnt), 32'd0);
    chk("midrst_ready", 32'(bus.r0_ready), 32'd0);
    idle();
    tick();
    rst = 1'b1;

    // Contention from reset alternates r0, r1, r0, r1.
    req(0, CmdAdd, 32'd1, 32'd2, 1'b0, 4'hA);
    req(1, CmdSub, 32'd10, 32'd3, 1'b0, 4'hB);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_r0_ready", 32'(bus.r0_ready), 32'((i % 2) == 0));
      chk("rr_r1_ready", 32'(bus.r1_ready), 32'((i % 2) == 1));
      tick();
      chk("rr_src", 32'(bus.out_src), 32'(i % 2));
    end
    idle();
    chk("rr_cnt", 32'(bus.grant_cnt), 32'd4);
    chk("rr_last_result", bus.out_result, 32'd7);

    // Backpressure: pending result holds, no grants until out_ready returns.
    req(0, CmdMov, 32'd0, 32'h1234, 1'b0, 4'd5);
    tick();
    idle();
    req(1, CmdAdd, 32'hFFFF_FFFF, 32'd2, 1'b1, 4'd9);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_r0_ready", 32'(bus.r0_ready), 32'd0);
      chk("stall_r1_ready", 32'(bus.r1_ready), 32'd0);
      chk("stall_result", bus.out_result, 32'h1234);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_tag", 32'(bus.out_tag), 32'd5);
      tick();
    end
    bus.out_ready = 1'b1;
    #1 chk("release_r1_ready", 32'(bus.r1_ready), 32'd1);
    tick();
    idle();
    chk("release_result", bus.out_result, 32'd1);
    chk("release_src", 32'(bus.out_src), 32'd1);
    chk("release_tag", 32'(bus.out_tag), 32'd9);
    chk("release_status", 32'(bus.status_reg), 32'h4);

    // Flush with a valid slot: grant blocked, slot emptied, flags and count held.
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    req(0, CmdAdd, 32'd0, 32'd0, 1'b1, 4'd1);
    #1 chk("flush_r0_ready", 32'(bus.r0_ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    idle();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_status", 32'(bus.status_reg), 32'h4);
    chk("flush_cnt", 32'(bus.grant_cnt), 32'd6);
    chk("model_flush", 32'(m_sreg), 32'h4);
    bus.out_ready = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
